// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and the E->M pipeline register layout.
package y86_pkg;

  // Instruction codes referenced by the memory stage
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Status codes
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  // "No register" destination
  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } mreg_t;

  // State loaded by both reset and bubble: a harmless NOP
  localparam mreg_t MREG_NOP = '{
    stat:  SAOK,
    icode: INOP,
    cnd:   1'b0,
    valE:  64'd0,
    valA:  64'd0,
    dstE:  RNONE,
    dstM:  RNONE
  };

endpackage

// File: rtl/data_memory.sv
// Byte-addressed little-endian data memory with 8-byte accesses.
// Reads are combinational; writes land on the rising clock edge.
// re flags an access of any kind (it drives the bounds check); we
// commits a write. Unaligned addresses are legal.
module data_memory #(
  parameter int MEM_BYTES = 8192
) (
  input  logic        clk,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [63:0] rdata,
  output logic        err
);

  localparam int          ADDR_W    = $clog2(MEM_BYTES);
  localparam logic [63:0] LAST_BASE = 64'(MEM_BYTES - 8);

  logic [7:0]        mem [MEM_BYTES];
  logic [ADDR_W-1:0] base;
  logic [63:0]       rd_raw;

  // Full 64-bit unsigned compare, so huge addresses never wrap into range
  assign err  = (re | we) & (addr > LAST_BASE);
  assign base = addr[ADDR_W-1:0];

  // Assemble 8 bytes, lowest address in the least significant byte
  always_comb begin
    rd_raw = '0;
    for (int i = 0; i < 8; i++) begin
      rd_raw[8*i +: 8] = mem[base + ADDR_W'(i)];
    end
  end

  assign rdata = (re & ~err) ? rd_raw : 64'd0;

  // Store 8 bytes little-endian; out-of-range stores are dropped
  always_ff @(posedge clk) begin
    if (we && !err) begin
      for (int i = 0; i < 8; i++) begin
        mem[base + ADDR_W'(i)] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory (M) stage: E->M pipeline register, data-memory access,
// and the M_*/m_* results used by writeback, forwarding and hazard control.
module memory_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        M_stall,
  input  logic        M_bubble,
  input  logic [2:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_Cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  output logic [3:0]  M_icode,
  output logic        M_Cnd,
  output logic [63:0] M_valA,
  output logic [2:0]  m_stat,
  output logic [3:0]  m_icode,
  output logic [63:0] m_valE,
  output logic [63:0] m_valM,
  output logic [3:0]  m_dstE,
  output logic [3:0]  m_dstM
);

  mreg_t       m_q, m_d;
  logic        mem_read, mem_write, wr_commit, dmem_error;
  logic [63:0] mem_addr, mem_rdata;

  // Next M register contents: bubble beats stall beats normal load
  always_comb begin
    m_d = m_q;
    if (M_bubble) begin
      m_d = MREG_NOP;
    end else if (!M_stall) begin
      m_d = '{stat: e_stat, icode: e_icode, cnd: e_Cnd, valE: e_valE,
              valA: e_valA, dstE: e_dstE, dstM: e_dstM};
    end
  end

  // E->M pipeline register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) m_q <= MREG_NOP;
    else        m_q <= m_d;
  end

  // Decode memory access kind and address source from the latched icode
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = m_q.valE;
    case (m_q.icode)
      IRMMOVQ, ICALL, IPUSHQ: mem_write = 1'b1;
      IMRMOVQ:                mem_read  = 1'b1;
      IRET, IPOPQ: begin
        mem_read = 1'b1;
        mem_addr = m_q.valA;
      end
      default: ;
    endcase
  end

  // A store is committed only for a healthy, advancing, non-reset instruction;
  // this way a stalled store is written once, and a store cut by reset is dropped
  assign wr_commit = mem_write & (m_q.stat == SAOK) & rst_n & ~M_stall;

  data_memory #(.MEM_BYTES(MEM_BYTES)) u_dmem (
    .clk   (clk),
    .addr  (mem_addr),
    .wdata (m_q.valA),
    .we    (wr_commit),
    .re    (mem_read | mem_write),
    .rdata (mem_rdata),
    .err   (dmem_error)
  );

  assign M_icode = m_q.icode;
  assign M_Cnd   = m_q.cnd;
  assign M_valA  = m_q.valA;
  assign m_stat  = dmem_error ? SADR : m_q.stat;
  assign m_icode = m_q.icode;
  assign m_valE  = m_q.valE;
  assign m_valM  = mem_read ? mem_rdata : 64'd0;
  assign m_dstE  = m_q.dstE;
  assign m_dstM  = m_q.dstM;

endmodule
